// File: rtl/mul_seq_controller_pkg.sv
// ----------------------------------------------------------------------------
// mul_seq_controller_pkg
// Shared datapath types used by every controller that drives the common
// ALU / shifter / register-file datapath.
//   alu_ctl_t   : ALU operation select
//   shift_amt_t : barrel-shifter amount
//   reg_sel_t   : register-file select (destination / operand A / operand B)
//   ctrl_t      : the complete control bundle a controller presents each cycle
// ----------------------------------------------------------------------------
package mul_seq_controller_pkg;

    typedef enum logic [3:0] {
        OP_ORR   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_B_PAS = 4'd3,
        OP_AND   = 4'd4,
        OP_EOR   = 4'd5
    } alu_ctl_t;

    typedef logic [2:0] shift_amt_t;
    typedef logic [2:0] reg_sel_t;

    typedef struct packed {
        alu_ctl_t   op;
        shift_amt_t sh;
        reg_sel_t   d;
        reg_sel_t   n;
        reg_sel_t   m;
        logic       dw;
    } ctrl_t;

endpackage

// File: rtl/mul_seq_controller.sv
// ----------------------------------------------------------------------------
// mul_seq_controller
// Sequences the shared datapath to compute R[RP] = R[RA] * R[RB] (unsigned),
// MSB-first shift-and-add over WIDTH iterations. R[RA] is preserved, R[RB]
// is shifted out to zero. A sticky ovf flag records any carry out of a
// doubling or an add.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : level request, accepted in S_IDLE only
//   busy, done        : handshake status
//   ovf               : sticky overflow (product wider than WIDTH bits)
//   op, sh, d, n, m   : datapath control bundle
//   dw                : register-file write enable
//   cn, cz, cc, cv    : ALU flags of the current cycle (only cc is used)
// ----------------------------------------------------------------------------
module mul_seq_controller
    import mul_seq_controller_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RA    = 0,
    parameter int RB    = 1,
    parameter int RP    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output alu_ctl_t   op,
    output shift_amt_t sh,
    output reg_sel_t   d,
    output reg_sel_t   n,
    output reg_sel_t   m,
    output logic       dw,
    input  logic       cn,
    input  logic       cz,
    input  logic       cc,
    input  logic       cv
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam reg_sel_t SEL_RA = reg_sel_t'(RA);
    localparam reg_sel_t SEL_RB = reg_sel_t'(RB);
    localparam reg_sel_t SEL_RP = reg_sel_t'(RP);
    localparam reg_sel_t SEL_R0 = reg_sel_t'(0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_DBL  = 3'd2;
    localparam logic [2:0] S_SHM  = 3'd3;
    localparam logic [2:0] S_ADD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntDec;
    logic          r_bit;
    logic          r_ovf;
    ctrl_t         w_ctrl;

    // Only the carry matters for an unsigned product; the other flags and the
    // captured multiplier bit are kept for interface parity with peer blocks.
    logic w_unused;
    assign w_unused = ^{cn, cz, cv, r_bit};

    // Packs one control bundle, mirroring the helper used by peer controllers.
    function automatic ctrl_t ctrl(input alu_ctl_t   f_op,
                                   input shift_amt_t f_sh,
                                   input reg_sel_t   f_d,
                                   input reg_sel_t   f_n,
                                   input reg_sel_t   f_m,
                                   input logic       f_dw);
        ctrl_t c;
        c.op = f_op;
        c.sh = f_sh;
        c.d  = f_d;
        c.n  = f_n;
        c.m  = f_m;
        c.dw = f_dw;
        return c;
    endfunction

    assign w_cntDec = r_cnt - CW'(1);

    // Next-state selection. After the multiplier shift, a set bit inserts an
    // add; the decremented counter is the only terminal test.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = start ? S_CLR : S_IDLE;
            S_CLR:  w_next = S_DBL;
            S_DBL:  w_next = S_SHM;
            S_SHM: begin
                if (cc)
                    w_next = S_ADD;
                else if (w_cntDec != '0)
                    w_next = S_DBL;
                else
                    w_next = S_DONE;
            end
            S_ADD:  w_next = (r_cnt != '0) ? S_DBL : S_DONE;
            S_DONE: w_next = start ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, iteration counter, captured bit and sticky overflow. The carry
    // sampled in S_DBL and S_ADD is the carry out of that cycle's ALU add on
    // the product register, so OR-ing it in catches every lost bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ovf <= 1'b0;
                        r_cnt <= CW'(WIDTH);
                    end
                end
                S_DBL: r_ovf <= r_ovf | cc;
                S_SHM: begin
                    r_bit <= cc;
                    r_cnt <= w_cntDec;
                end
                S_ADD: r_ovf <= r_ovf | cc;
                default: ;
            endcase
        end
    end

    // Control bundle is a pure decode of the state register; ALU flags never
    // reach the outputs combinationally.
    always_comb begin
        w_ctrl = ctrl(OP_ORR, '0, SEL_R0, SEL_R0, SEL_R0, 1'b0);
        case (r_state)
            S_CLR:  w_ctrl = ctrl(OP_SUB,   '0, SEL_RP, SEL_RP, SEL_RP, 1'b1);
            S_DBL:  w_ctrl = ctrl(OP_ADD,   '0, SEL_RP, SEL_RP, SEL_RP, 1'b1);
            S_SHM:  w_ctrl = ctrl(OP_ADD,   '0, SEL_RB, SEL_RB, SEL_RB, 1'b1);
            S_ADD:  w_ctrl = ctrl(OP_ADD,   '0, SEL_RP, SEL_RP, SEL_RA, 1'b1);
            S_DONE: w_ctrl = ctrl(OP_B_PAS, '0, SEL_R0, SEL_R0, SEL_RP, 1'b0);
            default: ;
        endcase
    end

    assign op   = w_ctrl.op;
    assign sh   = w_ctrl.sh;
    assign d    = w_ctrl.d;
    assign n    = w_ctrl.n;
    assign m    = w_ctrl.m;
    assign dw   = w_ctrl.dw;
    assign busy = (r_state == S_CLR) || (r_state == S_DBL) ||
                  (r_state == S_SHM) || (r_state == S_ADD);
    assign done = (r_state == S_DONE);
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_mul_seq_controller.sv
// ----------------------------------------------------------------------------
// tb_mul_seq_controller
// Drives mul_seq_controller against a behavioural register file + ALU.
// Expected products, overflow and latency come from plain arithmetic on the
// operands and are queued at issue time; a monitor pops them on each done.
// ----------------------------------------------------------------------------
module tb_mul_seq_controller;
    import mul_seq_controller_pkg::*;

    localparam int W = 8;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       ovf;
    alu_ctl_t   op;
    shift_amt_t sh;
    reg_sel_t   d;
    reg_sel_t   n;
    reg_sel_t   m;
    logic       dw;
    logic       cn;
    logic       cz;
    logic       cc;
    logic       cv;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] prod;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sbq[$];

    mul_seq_controller #(.WIDTH(W), .RA(0), .RB(1), .RP(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .op      (op),
        .sh      (sh),
        .d       (d),
        .n       (n),
        .m       (m),
        .dw      (dw),
        .cn      (cn),
        .cz      (cz),
        .cc      (cc),
        .cv      (cv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: an 8-entry register file and a small ALU.
    logic [W-1:0] regs [8];
    logic [W-1:0] aluRes;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         loadEn = 1'b0;
    logic [W-1:0] loadA  = '0;
    logic [W-1:0] loadB  = '0;
    logic [W-1:0] loadP  = '0;

    always_comb begin
        opA    = regs[n];
        opB    = regs[m];
        aluRes = '0;
        cc     = 1'b0;
        case (op)
            OP_ADD:   {cc, aluRes} = {1'b0, opA} + {1'b0, opB};
            OP_SUB:   begin aluRes = opA - opB; cc = (opA >= opB); end
            OP_ORR:   aluRes = opA | opB;
            OP_B_PAS: aluRes = opB;
            OP_AND:   aluRes = opA & opB;
            OP_EOR:   aluRes = opA ^ opB;
            default:  aluRes = '0;
        endcase
        cz = (aluRes == '0);
        cn = aluRes[W-1];
        cv = 1'b0;
    end

    always @(posedge clk) begin
        if (loadEn) begin
            regs[0] <= loadA;
            regs[1] <= loadB;
            regs[2] <= loadP;
        end else if (dw) begin
            regs[d] <= aluRes;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Monitor: tracks one operation from its first busy sample to done and
    // compares the datapath result with the queued expectation.
    bit inOp = 1'b0;
    int cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n || (!busy && !done)) begin
            inOp = 1'b0;
        end else begin
            if (busy && !inOp) begin
                inOp = 1'b1;
                cyc  = 0;
                checkOutput("ovfClearOnAccept", int'(ovf), 0);
            end else if (inOp) begin
                cyc++;
            end
            if (done && inOp) begin
                inOp = 1'b0;
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("product",   int'(regs[2]), int'(e.prod));
                    checkOutput("aluOutput", int'(aluRes),  int'(e.prod));
                    checkOutput("ovf",       int'(ovf),     int'(e.ovf));
                    checkOutput("latency",   cyc,           e.lat);
                    checkOutput("rbCleared", int'(regs[1]), 0);
                    checkOutput("raKept",    int'(regs[0]), int'(e.a));
                end
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   full;
        full   = int'(a) * int'(b);
        e.a    = a;
        e.prod = W'(full % (1 << W));
        e.ovf  = (full >= (1 << W));
        e.lat  = 1 + 2 * W + $countones(b);
        return e;
    endfunction

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (!busy && !done) break;
            @(negedge clk);
        end
        if (busy || done) checkOutput("idleTimeout", 0, 1);
    endtask

    task automatic loadRegs(input logic [W-1:0] a, input logic [W-1:0] b);
        loadA  = a;
        loadB  = b;
        loadP  = W'($urandom);
        loadEn = 1'b1;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    task automatic waitBusy();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        if (!busy) checkOutput("busyTimeout", 0, 1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) checkOutput("doneTimeout", 0, 1);
    endtask

    // Issues one multiply; returns at the first done sample with start still
    // high unless dropEarly released it right after acceptance.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit dropEarly);
        waitIdle();
        loadRegs(a, b);
        sbq.push_back(model(a, b));
        start = 1'b1;
        waitBusy();
        if (dropEarly) start = 1'b0;
        waitDone();
    endtask

    task automatic endOp();
        start = 1'b0;
        @(negedge clk);
        checkOutput("backToIdle", int'(busy | done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int shm;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetDw",   int'(dw),   0);
        checkOutput("resetOvf",  int'(ovf),  0);
        checkOutput("resetOp",   int'(op),   int'(OP_ORR));
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed products");
        applyStimulus(8'd13, 8'd11, 1'b0);  endOp();
        applyStimulus(8'd0,  8'd200, 1'b0); endOp();
        applyStimulus(8'd200, 8'd0, 1'b0);  endOp();
        applyStimulus(8'd255, 8'd255, 1'b0); endOp();
        checkOutput("ovfHeldInIdle", int'(ovf), 1);
        applyStimulus(8'd2, 8'd3, 1'b0);    endOp();

        $display("[TB] reset during multiplier shift of iteration 4");
        waitIdle();
        loadRegs(8'd100, 8'd255);
        start = 1'b1;
        waitBusy();
        start = 1'b0;
        shm = (busy && dw && d == reg_sel_t'(1)) ? 1 : 0;
        for (int i = 0; i < 60 && shm < 4; i++) begin
            @(negedge clk);
            if (busy && dw && d == reg_sel_t'(1)) shm++;
        end
        checkOutput("reachedShm4", shm, 4);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortDw",   int'(dw),   0);
        checkOutput("abortDone", int'(done), 0);
        checkOutput("abortRaKept", int'(regs[0]), 100);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'd7, 8'd9, 1'b0);    endOp();

        $display("[TB] start held past done");
        applyStimulus(8'd5, 8'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdDone", int'(done), 1);
            checkOutput("holdNoDw", int'(dw),   0);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("dropToIdle", int'(busy | done), 0);
        sbq.push_back(model(8'd5, 8'd0));
        start = 1'b1;
        @(negedge clk);
        checkOutput("restartBusy", int'(busy), 1);
        checkOutput("restartClr",  int'(op),   int'(OP_SUB));
        start = 1'b0;
        waitDone();
        endOp();

        $display("[TB] start dropped while busy");
        applyStimulus(8'd1, 8'd1, 1'b1);    endOp();

        $display("[TB] randomized products");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(1)));
            endOp();
        end

        checkOutput("scoreboardDrained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
